// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared width defaults and control encodings for the MIPS core.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int c_DATA_W  = 8;
    localparam int c_ADDR_W  = 8;
    localparam int c_RADDR_W = 5;

    // Writeback source select
    localparam logic MUX_ALU = 1'b0;
    localparam logic MUX_MEM = 1'b1;

    // Memory direction
    localparam logic MEM_LOAD  = 1'b0;
    localparam logic MEM_STORE = 1'b1;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/dm_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dm_ram
//  Description : Single-port synchronous read-first data RAM, 1-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int              c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] c_DEPTH = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic               w_in_range;
    logic [c_IDX_W-1:0] w_idx;

    assign w_in_range = ({1'b0, addr} < c_DEPTH);
    assign w_idx      = addr[c_IDX_W-1:0];

    // Array is never reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && en && we && w_in_range) begin
            r_mem[w_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= '0;
        end else if (en) begin
            dout <= w_in_range ? r_mem[w_idx] : '0;
        end
    end

endmodule : dm_ram
`default_nettype wire

// File: rtl/data_memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_stage
//  Description : MEM pipeline stage: EX->MEM register, data RAM, writeback mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int ADDR_W  = c_ADDR_W,
    parameter int DEPTH   = 256,
    parameter int RADDR_W = c_RADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               valid_ex,
    input  logic [DATA_W-1:0]  ans_ex,
    input  logic [DATA_W-1:0]  B_Bypass,
    input  logic [RADDR_W-1:0] RW_ex,
    input  logic               mem_en_ex,
    input  logic               mem_rw_ex,
    input  logic               mem_mux_sel_ex,
    output logic [DATA_W-1:0]  mux_ans_dm,
    output logic [RADDR_W-1:0] RW_dm,
    output logic               valid_dm,
    output logic               mem_err_dm
);

    localparam logic [ADDR_W:0] c_DEPTH = DEPTH[ADDR_W:0];

    logic [ADDR_W-1:0] w_addr;
    logic              w_in_range;
    logic              w_live;
    logic              w_acc;
    logic              w_we;
    logic [DATA_W-1:0] w_ram_q;
    logic [DATA_W-1:0] r_ans;
    logic              r_mem_mux_sel;

    assign w_addr     = ans_ex[ADDR_W-1:0];
    assign w_in_range = ({1'b0, w_addr} < c_DEPTH);
    assign w_live     = valid_ex & ~flush;
    assign w_acc      = w_live & mem_en_ex & ~stall;
    assign w_we       = (mem_rw_ex == MEM_STORE);

    dm_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_dm_ram (
        .clk   (clk),
        .reset (reset),
        .en    (w_acc),
        .we    (w_we),
        .addr  (w_addr),
        .din   (B_Bypass),
        .dout  (w_ram_q)
    );

    // Stall takes priority over flush: the EX instruction survives a stalled cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ans         <= '0;
            RW_dm         <= '0;
            r_mem_mux_sel <= 1'b0;
            valid_dm      <= 1'b0;
            mem_err_dm    <= 1'b0;
        end else if (!stall) begin
            r_ans         <= ans_ex;
            RW_dm         <= w_live ? RW_ex : '0;
            r_mem_mux_sel <= w_live ? mem_mux_sel_ex : MUX_ALU;
            valid_dm      <= w_live;
            mem_err_dm    <= w_live & mem_en_ex & ~w_in_range;
        end
    end

    assign mux_ans_dm = (r_mem_mux_sel == MUX_MEM) ? w_ram_q : r_ans;

endmodule : data_memory_stage
`default_nettype wire

// File: tb/tb_data_memory_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_stage
//  Description : Directed vector bench for data_memory_stage (DEPTH=128).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_stage;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       flush;
    logic       valid_ex;
    logic [7:0] ans_ex;
    logic [7:0] B_Bypass;
    logic [4:0] RW_ex;
    logic       mem_en_ex;
    logic       mem_rw_ex;
    logic       mem_mux_sel_ex;
    logic [7:0] mux_ans_dm;
    logic [4:0] RW_dm;
    logic       valid_dm;
    logic       mem_err_dm;

    int n_checks;
    int n_errors;

    data_memory_stage #(
        .DATA_W  (8),
        .ADDR_W  (8),
        .DEPTH   (128),
        .RADDR_W (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .valid_ex       (valid_ex),
        .ans_ex         (ans_ex),
        .B_Bypass       (B_Bypass),
        .RW_ex          (RW_ex),
        .mem_en_ex      (mem_en_ex),
        .mem_rw_ex      (mem_rw_ex),
        .mem_mux_sel_ex (mem_mux_sel_ex),
        .mux_ans_dm     (mux_ans_dm),
        .RW_dm          (RW_dm),
        .valid_dm       (valid_dm),
        .mem_err_dm     (mem_err_dm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       stall;
        logic       flush;
        logic       valid;
        logic [7:0] ans;
        logic [7:0] bdat;
        logic [4:0] rw;
        logic       en;
        logic       mrw;
        logic       sel;
        logic [7:0] x_mux;
        logic [4:0] x_rw;
        logic       x_valid;
        logic       x_err;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] m, input logic [4:0] r,
                            input logic v, input logic e);
        chk({tag, ".mux"},   {24'd0, mux_ans_dm}, {24'd0, m});
        chk({tag, ".rw"},    {27'd0, RW_dm},      {27'd0, r});
        chk({tag, ".valid"}, {31'd0, valid_dm},   {31'd0, v});
        chk({tag, ".err"},   {31'd0, mem_err_dm}, {31'd0, e});
    endtask

    task automatic drive(input logic s, input logic f, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [4:0] r, input logic en,
                         input logic mrw, input logic sel);
        stall = s; flush = f; valid_ex = v; ans_ex = a; B_Bypass = b;
        RW_ex = r; mem_en_ex = en; mem_rw_ex = mrw; mem_mux_sel_ex = sel;
    endtask

    // Present one EX instruction, clock it, then check the MEM outputs.
    task automatic step(input string tag, input logic s, input logic f, input logic v,
                        input logic [7:0] a, input logic [7:0] b, input logic [4:0] r,
                        input logic en, input logic mrw, input logic sel,
                        input logic [7:0] xm, input logic [4:0] xr, input logic xv,
                        input logic xe);
        drive(s, f, v, a, b, r, en, mrw, sel);
        @(posedge clk); #1;
        chk_outs(tag, xm, xr, xv, xe);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        // stall flush valid ans  bdat  rw    en   mrw  sel  | mux   rw    v    err
        vt[0]  = '{1'b0, 1'b0, 1'b1, 8'h10, 8'hA5, 5'd0, 1'b1, 1'b1, 1'b0, 8'h10, 5'd0, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 5'd3, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd3, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 8'h99, 5'd7, 1'b0, 1'b1, 1'b0, 8'h3C, 5'd7, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 5'd4, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd4, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 8'h20, 8'h5A, 5'd0, 1'b1, 1'b1, 1'b0, 8'h20, 5'd0, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 8'h20, 8'h77, 5'd9, 1'b1, 1'b1, 1'b1, 8'h20, 5'd0, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 5'd2, 1'b1, 1'b0, 1'b1, 8'h5A, 5'd2, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 8'h90, 8'h33, 5'd0, 1'b1, 1'b1, 1'b0, 8'h90, 5'd0, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 8'h90, 8'h00, 5'd6, 1'b1, 1'b0, 1'b1, 8'h00, 5'd6, 1'b1, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 5'd1, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 8'h44, 8'h00, 5'd5, 1'b1, 1'b0, 1'b1, 8'h44, 5'd0, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b1, 1'b1, 8'h95, 8'h00, 5'd5, 1'b1, 1'b0, 1'b1, 8'h95, 5'd0, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b1, 8'h10, 8'hEE, 5'd0, 1'b1, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0};
        vt[13] = '{1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 5'd8, 1'b1, 1'b0, 1'b1, 8'hEE, 5'd8, 1'b1, 1'b0};

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 8'h00, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step($sformatf("vec%0d", i), vt[i].stall, vt[i].flush, vt[i].valid, vt[i].ans,
                 vt[i].bdat, vt[i].rw, vt[i].en, vt[i].mrw, vt[i].sel,
                 vt[i].x_mux, vt[i].x_rw, vt[i].x_valid, vt[i].x_err);
        end

        // Stall: outputs freeze, store under stall is ignored, stall beats flush.
        step("stall_ld", 1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 5'd11, 1'b1, 1'b0, 1'b1,
             8'h5A, 5'd11, 1'b1, 1'b0);
        step("stall1", 1'b1, 1'b0, 1'b1, 8'h20, 8'h11, 5'd0, 1'b1, 1'b1, 1'b0,
             8'h5A, 5'd11, 1'b1, 1'b0);
        step("stall2", 1'b1, 1'b1, 1'b1, 8'h90, 8'h22, 5'd13, 1'b1, 1'b0, 1'b0,
             8'h5A, 5'd11, 1'b1, 1'b0);
        step("stall3", 1'b1, 1'b0, 1'b0, 8'h3C, 8'h11, 5'd14, 1'b1, 1'b1, 1'b0,
             8'h5A, 5'd11, 1'b1, 1'b0);
        step("post_stall", 1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 5'd12, 1'b1, 1'b0, 1'b1,
             8'h5A, 5'd12, 1'b1, 1'b0);

        // Asynchronous reset between edges, with a store pending on the reset edge.
        #3 reset = 1'b0;
        #1 chk_outs("async_rst", 8'h00, 5'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h10, 8'hFF, 5'd0, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk_outs("rst_hold", 8'h00, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        step("rst_ld10", 1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 5'd15, 1'b1, 1'b0, 1'b1,
             8'hEE, 5'd15, 1'b1, 1'b0);
        step("rst_ld20", 1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 5'd16, 1'b1, 1'b0, 1'b1,
             8'h5A, 5'd16, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_data_memory_stage
`default_nettype wire
